rx_frame_ctrl: RTL

Receive-side sequencer for the RMII Ethernet path. It sits between the PHY dibit interface and the payload pipeline (checksum and 32-bit word aggregator). It strips preamble/SFD and gates payload dibits into the pipeline. It then waits for the checksum verdict and commits the captured 32-bit word to a one-entry ready/valid output buffer, keeping good/bad/drop frame counters.

---
 rtl/rx_pkg.sv | 7 +
 rtl/rx_out_buf.sv | 23 ++
 rtl/rx_frame_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// rx_pkg: shared FSM state type, RMII dibit constants and default frame length for the receive path
package rx_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, CHECK, IGNORE} rx_state_t;
  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;
  localparam int DEF_MIN_DIBITS = 256;
endpackage

// File: rtl/rx_out_buf.sv
// rx_out_buf: one-entry ready/valid word register; load/din in, valid/dout out, full when it cannot take a load this cycle
module rx_out_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         full
);
  assign full = valid && !ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) valid <= 1'b0;
endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: RMII receive sequencer; strips preamble/SFD, forwards payload dibits, commits checksum-approved words and counts good/bad/dropped frames
module rx_frame_ctrl import rx_pkg::*; #(
  parameter int PRE_MIN     = 8,
  parameter int MIN_DIBITS  = DEF_MIN_DIBITS,
  parameter int CHK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             crsdv,
  input  logic [1:0]       rxd,
  output logic             dat_valid,
  output logic [1:0]       dat,
  input  logic             cksum_done,
  input  logic             cksum_kill,
  input  logic             agg_valid,
  input  logic [31:0]      agg_data,
  output logic             word_valid,
  output logic [31:0]      word_data,
  input  logic             word_ready,
  output logic [CNT_W-1:0] good_frames,
  output logic [CNT_W-1:0] bad_frames,
  output logic [CNT_W-1:0] drop_frames
);
  localparam int PW = $clog2(PRE_MIN + 1);
  localparam int DW = $clog2(MIN_DIBITS + 1);
  localparam int TW = $clog2(CHK_TIMEOUT + 1);
  rx_state_t state, state_n;
  logic [PW-1:0] pre_cnt, pre_n;
  logic [DW-1:0] dib_cnt, dib_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [31:0] cap_word, cw_n;
  logic cap_flag, cf_n, dv_n, decide, good, tmo_hit, pre_bad, load, full;
  always_comb begin
    state_n = state;
    pre_n   = pre_cnt;
    dib_n   = dib_cnt;
    tmo_n   = tmo;
    cw_n    = cap_word;
    cf_n    = cap_flag;
    dv_n    = 1'b0;
    decide  = 1'b0;
    tmo_hit = 1'b0;
    pre_bad = 1'b0;
    if ((state == PAYLOAD || state == CHECK) && agg_valid) begin
      cw_n = agg_data;
      cf_n = 1'b1;
    end
    case (state)
      IDLE: if (crsdv) begin
        state_n = rxd == PRE_DIBIT ? PREAMBLE : IGNORE;
        pre_n   = PW'(1);
      end
      PREAMBLE:
        if (!crsdv) state_n = IDLE;
        else if (rxd == PRE_DIBIT) pre_n = pre_cnt == PW'(PRE_MIN) ? pre_cnt : pre_cnt + 1'b1;
        else if (rxd == SFD_DIBIT && pre_cnt >= PW'(PRE_MIN)) begin
          state_n = PAYLOAD;
          dib_n   = '0;
          cf_n    = 1'b0;
        end else begin
          state_n = IGNORE;
          pre_bad = 1'b1;
        end
      PAYLOAD:
        if (crsdv) begin
          dv_n  = 1'b1;
          dib_n = dib_cnt == DW'(MIN_DIBITS) ? dib_cnt : dib_cnt + 1'b1;
        end else begin
          // a verdict coinciding with carrier drop is decided right away
          state_n = CHECK;
          tmo_n   = '0;
          decide  = cksum_done;
        end
      CHECK: begin
        decide  = cksum_done;
        tmo_hit = !cksum_done && tmo == TW'(CHK_TIMEOUT - 1);
        tmo_n   = tmo + 1'b1;
      end
      default: if (!crsdv) state_n = IDLE;
    endcase
    good = !cksum_kill && dib_cnt >= DW'(MIN_DIBITS) && cf_n;
    if (decide || tmo_hit) state_n = crsdv ? IGNORE : IDLE;
    load = decide && good && !full;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      pre_cnt     <= '0;
      dib_cnt     <= '0;
      tmo         <= '0;
      cap_word    <= '0;
      cap_flag    <= 1'b0;
      dat_valid   <= 1'b0;
      dat         <= '0;
      good_frames <= '0;
      bad_frames  <= '0;
      drop_frames <= '0;
    end else begin
      state       <= state_n;
      pre_cnt     <= pre_n;
      dib_cnt     <= dib_n;
      tmo         <= tmo_n;
      cap_word    <= cw_n;
      cap_flag    <= cf_n;
      dat_valid   <= dv_n;
      dat         <= dv_n ? rxd : 2'b00;
      good_frames <= good_frames + CNT_W'(load);
      bad_frames  <= bad_frames + CNT_W'(pre_bad || tmo_hit || (decide && !good));
      drop_frames <= drop_frames + CNT_W'(decide && good && full);
    end
  rx_out_buf #(.W(32)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (cw_n),
    .ready(word_ready),
    .valid(word_valid),
    .dout (word_data),
    .full (full)
  );
endmodule
